sid_reader: RTL and testbench

Bus-initiator counterpart of the SCSI ID configuration register. It runs read and write cycles against the register through the sid_cycle/DOE/DS0_n/READ/dtack handshake, captures the returned byte, and publishes decoded configuration fields to the SCSI core. An automatic read after reset loads the power-on configuration. Software-triggered reload and write-back are also supported.

---
 rtl/sid_reader_pkg.sv | 23 ++
 rtl/sid_reader_if.sv | 21 ++
 rtl/sid_timeout_ctr.sv | 29 ++
 rtl/sid_reader.sv | 136 +++++++++++++
 tb/tb_sid_reader.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sid_reader_pkg.sv
// Shared types and constants for the SCSI ID configuration reader.
// Field bit positions follow the layout of the configuration byte.
package sid_reader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StStrobe,
    StRelease
  } sid_state_e;

  localparam int unsigned ID_LSB = 0;
  localparam int unsigned ID_MSB = 2;
  localparam int unsigned FAST   = 3;
  localparam int unsigned SPINUP = 4;
  localparam int unsigned SYNC   = 5;
  localparam int unsigned TERM   = 6;
  localparam int unsigned LUNS   = 7;

  // ID 7, fast, short spinup, sync, ext term, LUNs disabled
  localparam logic [7:0] CFG_DEFAULT_BYTE = 8'hFF;

endpackage

// File: rtl/sid_reader_if.sv
// Register-side handshake bus between the configuration reader (master)
// and the SCSI ID register (slave).
interface sid_reader_if;
  logic       sid_cycle;
  logic       DOE;
  logic       DS0_n;
  logic       READ;
  logic [7:0] DOUT;
  logic [7:0] DIN;
  logic       dtack;

  modport master (
    output sid_cycle, DOE, DS0_n, READ, DOUT,
    input  DIN, dtack
  );

  modport slave (
    input  sid_cycle, DOE, DS0_n, READ, DOUT,
    output DIN, dtack
  );
endinterface

// File: rtl/sid_timeout_ctr.sv
// Loadable saturating down-counter for bus acknowledge timeouts.
// expire is high while the count sits at zero.
module sid_timeout_ctr #(
  parameter int unsigned Width = 6
) (
  input  logic             clk,
  input  logic             IORST,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (IORST || clear) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/sid_reader.sv
// Bus initiator for the SCSI ID configuration register: runs read/write
// cycles, captures the returned byte and publishes the decoded fields.
module sid_reader
  import sid_reader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          AUTO_LOAD      = 1'b1,
  parameter logic [7:0]  CFG_DEFAULT    = CFG_DEFAULT_BYTE
) (
  input  logic         clk,
  input  logic         IORST,
  input  logic         rd_req,
  input  logic         wr_req,
  input  logic [7:0]   wr_data,
  sid_reader_if.master bus,
  output logic         busy,
  output logic         cfg_valid,
  output logic [7:0]   cfg_byte,
  output logic [2:0]   scsi_id,
  output logic         fast_en,
  output logic         short_spinup,
  output logic         sync_en,
  output logic         ext_term,
  output logic         luns_dis,
  output logic         timeout_err
);

  localparam int unsigned CtrW = $clog2(TIMEOUT_CYCLES);

  sid_state_e state_q;
  logic       first_q;
  logic       sid_cycle_q;
  logic       doe_q;
  logic       ds0_n_q;
  logic       read_q;
  logic [7:0] dout_q;
  logic       busy_q;
  logic       cfg_valid_q;
  logic [7:0] cfg_byte_q;
  logic       timeout_err_q;
  logic       ctr_expire;

  // Loaded in SETUP so the first STROBE cycle sees TIMEOUT_CYCLES-1
  sid_timeout_ctr #(
    .Width(CtrW)
  ) u_timeout_ctr (
    .clk     (clk),
    .IORST   (IORST),
    .clear   (state_q == StRelease),
    .load    (state_q == StSetup),
    .load_val(CtrW'(TIMEOUT_CYCLES - 1)),
    .en      (state_q == StStrobe),
    .expire  (ctr_expire)
  );

  always_ff @(posedge clk) begin
    if (IORST) begin
      state_q       <= StIdle;
      first_q       <= 1'b1;
      sid_cycle_q   <= 1'b0;
      doe_q         <= 1'b0;
      ds0_n_q       <= 1'b1;
      read_q        <= 1'b1;
      dout_q        <= 8'h00;
      busy_q        <= 1'b0;
      cfg_valid_q   <= 1'b0;
      cfg_byte_q    <= CFG_DEFAULT;
      timeout_err_q <= 1'b0;
    end else begin
      first_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rd_req || wr_req || (AUTO_LOAD && first_q)) begin
            state_q     <= StSetup;
            busy_q      <= 1'b1;
            sid_cycle_q <= 1'b1;
            // A simultaneous read request wins over the write
            if (wr_req && !rd_req) begin
              read_q <= 1'b0;
              dout_q <= wr_data;
            end else begin
              read_q <= 1'b1;
              dout_q <= 8'h00;
            end
          end
        end
        StSetup: begin
          state_q <= StStrobe;
          doe_q   <= 1'b1;
          ds0_n_q <= 1'b0;
        end
        StStrobe: begin
          if (bus.dtack || ctr_expire) begin
            state_q     <= StRelease;
            sid_cycle_q <= 1'b0;
            doe_q       <= 1'b0;
            ds0_n_q     <= 1'b1;
            read_q      <= 1'b1;
            if (bus.dtack) begin
              timeout_err_q <= 1'b0;
              if (read_q) begin
                cfg_byte_q  <= bus.DIN;
                cfg_valid_q <= 1'b1;
              end
            end else begin
              timeout_err_q <= 1'b1;
            end
          end
        end
        StRelease: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sid_cycle = sid_cycle_q;
  assign bus.DOE       = doe_q;
  assign bus.DS0_n     = ds0_n_q;
  assign bus.READ      = read_q;
  assign bus.DOUT      = dout_q;

  assign busy         = busy_q;
  assign cfg_valid    = cfg_valid_q;
  assign cfg_byte     = cfg_byte_q;
  assign timeout_err  = timeout_err_q;
  assign scsi_id      = cfg_byte_q[ID_MSB:ID_LSB];
  assign fast_en      = cfg_byte_q[FAST];
  assign short_spinup = cfg_byte_q[SPINUP];
  assign sync_en      = cfg_byte_q[SYNC];
  assign ext_term     = cfg_byte_q[TERM];
  assign luns_dis     = cfg_byte_q[LUNS];

endmodule

// File: tb/tb_sid_reader.sv
// Bench for sid_reader: behavioural register responder plus a scoreboard of
// expected bus cycles checked whenever a strobe window closes.
module tb_sid_reader;

  localparam int KRD = 0;
  localparam int KWR = 1;
  localparam int KTO = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         len;
  } exp_t;

  logic       clk;
  logic       IORST;
  logic       rd_req;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       busy, cfg_valid, fast_en, short_spinup, sync_en, ext_term, luns_dis;
  logic       timeout_err;
  logic [7:0] cfg_byte;
  logic [2:0] scsi_id;

  sid_reader_if bus ();

  sid_reader #(
    .TIMEOUT_CYCLES(8),
    .AUTO_LOAD     (1'b1),
    .CFG_DEFAULT   (8'hFF)
  ) dut (
    .clk         (clk),
    .IORST       (IORST),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .bus         (bus),
    .busy        (busy),
    .cfg_valid   (cfg_valid),
    .cfg_byte    (cfg_byte),
    .scsi_id     (scsi_id),
    .fast_en     (fast_en),
    .short_spinup(short_spinup),
    .sync_en     (sync_en),
    .ext_term    (ext_term),
    .luns_dis    (luns_dis),
    .timeout_err (timeout_err)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_cycles = 0;
  exp_t       sb[$];
  logic [7:0] exp_cfg = 8'hFF;

  // Responder: registered dtack resp_delay cycles into the strobe
  logic       resp_en = 1'b1;
  int         resp_delay = 1;
  logic [7:0] resp_reg = 8'h2B;
  logic       dtack_r = 1'b0;
  int         dcnt = 0;

  assign bus.DIN   = resp_reg;
  assign bus.dtack = dtack_r;

  always @(posedge clk) begin
    if (!bus.sid_cycle || bus.DS0_n) begin
      dtack_r <= 1'b0;
      dcnt    <= 0;
    end else if (resp_en && !dtack_r) begin
      if (dcnt >= resp_delay - 1) begin
        dtack_r <= 1'b1;
        if (!bus.READ) resp_reg <= bus.DOUT;
      end else begin
        dcnt <= dcnt + 1;
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: records each strobe window and checks it on close
  initial begin
    exp_t       e;
    logic       in_stb;
    logic       stb_read;
    logic       stb_ok;
    logic [7:0] stb_dout;
    int         stb_len;
    in_stb = 1'b0;
    stb_read = 1'b1;
    stb_ok = 1'b1;
    stb_dout = 8'h00;
    stb_len = 0;
    forever begin
      @(negedge clk);
      if (IORST) begin
        in_stb  = 1'b0;
        stb_len = 0;
      end else if (!bus.DS0_n) begin
        if (!in_stb) begin
          in_stb   = 1'b1;
          stb_read = bus.READ;
          stb_dout = bus.DOUT;
          stb_ok   = 1'b1;
          stb_len  = 0;
        end
        stb_len++;
        if (!bus.sid_cycle || !bus.DOE || bus.READ !== stb_read || bus.DOUT !== stb_dout)
          stb_ok = 1'b0;
      end else if (in_stb) begin
        in_stb = 1'b0;
        n_cycles++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_cycle: got cycle READ=%0b, want none", stb_read);
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if (stb_len != e.len) begin
            n_fail++;
            $display("FAIL sb_strobe_len: got %0d want %0d", stb_len, e.len);
          end
          n_cmp++;
          if (!stb_ok) begin
            n_fail++;
            $display("FAIL sb_strobe_stable: got unstable window, want stable");
          end
          n_cmp++;
          case (e.kind)
            KRD: begin
              if (stb_read !== 1'b1 || cfg_byte !== e.data || timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL sb_read: got READ=%0b cfg=%h terr=%0b want READ=1 cfg=%h terr=0",
                         stb_read, cfg_byte, timeout_err, e.data);
              end
              exp_cfg = e.data;
            end
            KWR: begin
              if (stb_read !== 1'b0 || stb_dout !== e.data || cfg_byte !== exp_cfg) begin
                n_fail++;
                $display("FAIL sb_write: got READ=%0b DOUT=%h cfg=%h want READ=0 DOUT=%h cfg=%h",
                         stb_read, stb_dout, cfg_byte, e.data, exp_cfg);
              end
            end
            default: begin
              if (timeout_err !== 1'b1 || cfg_byte !== exp_cfg) begin
                n_fail++;
                $display("FAIL sb_timeout: got terr=%0b cfg=%h want terr=1 cfg=%h",
                         timeout_err, cfg_byte, exp_cfg);
              end
            end
          endcase
        end
      end
    end
  end

  task automatic push_exp(input int kind, input logic [7:0] data, input int len);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.len  = len;
    sb.push_back(e);
  endtask

  task automatic pulse(input logic rd, input logic wr, input logic [7:0] d);
    rd_req  = rd;
    wr_req  = wr;
    wr_data = d;
    @(negedge clk);
    rd_req  = 1'b0;
    wr_req  = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n;
    bit rose;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    rose = busy;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    ok = rose && !busy;
  endtask

  task automatic test_reset();
    IORST = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.sid_cycle !== 1'b0 || bus.DOE !== 1'b0 || bus.DS0_n !== 1'b1 ||
        bus.READ !== 1'b1 || bus.DOUT !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: got sc=%0b doe=%0b ds=%0b rd=%0b dout=%h want 0 0 1 1 00",
               bus.sid_cycle, bus.DOE, bus.DS0_n, bus.READ, bus.DOUT);
    end
    n_cmp++;
    if (busy !== 1'b0 || cfg_valid !== 1'b0 || cfg_byte !== 8'hFF || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%0b vld=%0b cfg=%h terr=%0b want 0 0 ff 0",
               busy, cfg_valid, cfg_byte, timeout_err);
    end
    n_cmp++;
    if (scsi_id !== 3'd7 || luns_dis !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_decode: got id=%0d luns=%0b want 7 1", scsi_id, luns_dis);
    end
    exp_cfg = 8'hFF;
    push_exp(KRD, 8'h2B, 2);
    IORST = 1'b0;
  endtask

  task automatic test_autoload();
    bit ok;
    wait_idle(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL auto_done: got busy=%0b, want cycle completed", busy);
    end
    n_cmp++;
    if (cfg_valid !== 1'b1 || cfg_byte !== 8'h2B) begin
      n_fail++;
      $display("FAIL auto_cfg: got vld=%0b cfg=%h want 1 2b", cfg_valid, cfg_byte);
    end
    n_cmp++;
    if (scsi_id !== 3'd3 || fast_en !== 1'b1 || short_spinup !== 1'b0 || sync_en !== 1'b1 ||
        ext_term !== 1'b0 || luns_dis !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_decode: got id=%0d f=%0b s=%0b y=%0b t=%0b l=%0b want 3 1 0 1 0 0",
               scsi_id, fast_en, short_spinup, sync_en, ext_term, luns_dis);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL auto_sb_empty: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_write();
    bit ok;
    push_exp(KWR, 8'h5A, 2);
    pulse(1'b0, 1'b1, 8'h5A);
    n_cmp++;
    if (bus.sid_cycle !== 1'b1 || bus.READ !== 1'b0 || bus.DOUT !== 8'h5A ||
        bus.DOE !== 1'b0 || bus.DS0_n !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_setup: got sc=%0b rd=%0b dout=%h doe=%0b ds=%0b want 1 0 5a 0 1",
               bus.sid_cycle, bus.READ, bus.DOUT, bus.DOE, bus.DS0_n);
    end
    wait_idle(ok);
    n_cmp++;
    if (!ok || cfg_byte !== 8'h2B) begin
      n_fail++;
      $display("FAIL wr_cfg_kept: got done=%0b cfg=%h want 1 2b", ok, cfg_byte);
    end
    push_exp(KRD, 8'h5A, 2);
    pulse(1'b1, 1'b0, 8'h00);
    wait_idle(ok);
    n_cmp++;
    if (!ok || cfg_byte !== 8'h5A) begin
      n_fail++;
      $display("FAIL wr_readback: got done=%0b cfg=%h want 1 5a", ok, cfg_byte);
    end
  endtask

  task automatic test_rd_wr_collision();
    bit ok;
    int c0;
    c0 = n_cycles;
    push_exp(KRD, 8'h5A, 2);
    pulse(1'b1, 1'b1, 8'h11);
    wait_idle(ok);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (!ok || n_cycles - c0 != 1 || resp_reg !== 8'h5A) begin
      n_fail++;
      $display("FAIL collision: got done=%0b cycles=%0d reg=%h want 1 1 5a",
               ok, n_cycles - c0, resp_reg);
    end
  endtask

  task automatic test_req_during_strobe();
    bit ok;
    int c0;
    int n;
    resp_delay = 3;
    c0 = n_cycles;
    push_exp(KRD, 8'h5A, 4);
    pulse(1'b1, 1'b0, 8'h00);
    n = 0;
    while (bus.DS0_n && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus.DS0_n !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_seen: got DS0_n=%0b want 0", bus.DS0_n);
    end
    pulse(1'b1, 1'b1, 8'hEE);
    wait_idle(ok);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (!ok || n_cycles - c0 != 1 || sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy_req: got done=%0b cycles=%0d pend=%0d busy=%0b want 1 1 0 0",
               ok, n_cycles - c0, sb.size(), busy);
    end
    resp_delay = 1;
  endtask

  task automatic test_timeout();
    bit ok;
    resp_en = 1'b0;
    IORST = 1'b1;
    repeat (2) @(negedge clk);
    exp_cfg = 8'hFF;
    push_exp(KTO, 8'hFF, 8);
    IORST = 1'b0;
    wait_idle(ok);
    n_cmp++;
    if (!ok || timeout_err !== 1'b1 || cfg_byte !== 8'hFF || cfg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: got done=%0b terr=%0b cfg=%h vld=%0b want 1 1 ff 0",
               ok, timeout_err, cfg_byte, cfg_valid);
    end
    resp_en = 1'b1;
    push_exp(KRD, 8'h5A, 2);
    pulse(1'b1, 1'b0, 8'h00);
    wait_idle(ok);
    n_cmp++;
    if (!ok || timeout_err !== 1'b0 || cfg_valid !== 1'b1 || cfg_byte !== 8'h5A) begin
      n_fail++;
      $display("FAIL timeout_clear: got done=%0b terr=%0b vld=%0b cfg=%h want 1 0 1 5a",
               ok, timeout_err, cfg_valid, cfg_byte);
    end
  endtask

  task automatic test_reset_mid_strobe();
    bit ok;
    int n;
    pulse(1'b1, 1'b0, 8'h00);
    n = 0;
    while (!(bus.DS0_n === 1'b0 && bus.dtack === 1'b1) && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus.DS0_n !== 1'b0 || bus.dtack !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_dtack_seen: got DS0_n=%0b dtack=%0b want 0 1", bus.DS0_n, bus.dtack);
    end
    IORST = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.DS0_n !== 1'b1 || bus.DOE !== 1'b0 || bus.sid_cycle !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_abort_bus: got ds=%0b doe=%0b sc=%0b busy=%0b want 1 0 0 0",
               bus.DS0_n, bus.DOE, bus.sid_cycle, busy);
    end
    n_cmp++;
    if (cfg_byte !== 8'hFF || cfg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_no_capture: got cfg=%h vld=%0b want ff 0", cfg_byte, cfg_valid);
    end
    @(negedge clk);
    exp_cfg = 8'hFF;
    push_exp(KRD, 8'h5A, 2);
    IORST = 1'b0;
    wait_idle(ok);
    n_cmp++;
    if (!ok || cfg_byte !== 8'h5A || sb.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reload: got done=%0b cfg=%h pend=%0d want 1 5a 0",
               ok, cfg_byte, sb.size());
    end
  endtask

  initial begin
    IORST   = 1'b1;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    wr_data = 8'h00;
    test_reset();
    test_autoload();
    test_write();
    test_rd_wr_collision();
    test_req_during_strobe();
    test_timeout();
    test_reset_mid_strobe();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
